// File: rtl/adder_pkg.sv
// ============================================================================
// adder_pkg : shared constants and types for the adder32 add path
// Rev 1.0   : initial release
// ============================================================================
`default_nettype none

package adder_pkg;

  localparam int ADDER_WIDTH = 32;
  localparam int CLA_BLOCK   = 4;

  typedef logic [ADDER_WIDTH-1:0] word_t;

endpackage : adder_pkg

`default_nettype wire

// File: rtl/cla4.sv
// ============================================================================
// cla4 : 4-bit carry-lookahead block with per-bit generate/propagate
// Rev 1.0   : initial release
// ============================================================================
`default_nettype none

module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       c_out
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Every internal carry is a flat sum of products of c_in and the g/p terms.
  assign w_c[0] = c_in;
  assign w_c[1] = w_g[0]
                | (w_p[0] & c_in);
  assign w_c[2] = w_g[1]
                | (w_p[1] & w_g[0])
                | (w_p[1] & w_p[0] & c_in);
  assign w_c[3] = w_g[2]
                | (w_p[2] & w_g[1])
                | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & c_in);
  assign w_c[4] = w_g[3]
                | (w_p[3] & w_g[2])
                | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & c_in);

  assign s     = w_p ^ w_c[3:0];
  assign c_out = w_c[4];

endmodule : cla4

`default_nettype wire

// File: rtl/adder32.sv
// ============================================================================
// adder32 : registered WIDTH-bit adder built from chained cla4 blocks.
//           Define ADDER_OVERFLOW_EN to add the registered signed-overflow port.
// Rev 1.0   : initial release
// ============================================================================
`default_nettype none

module adder32
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid
`ifdef ADDER_OVERFLOW_EN
  ,
  output logic             of
`endif
);

  localparam int c_num_blk = WIDTH / CLA_BLOCK;

  generate
    if ((WIDTH % CLA_BLOCK) != 0) begin : g_width_check
      $error("adder32: WIDTH must be a multiple of 4");
    end
  endgenerate

  logic [WIDTH-1:0]   w_sum;
  logic [c_num_blk:0] w_carry;

  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_valid;

  assign w_carry[0] = cin;

  // Group carry ripples from one lookahead block into the next.
  generate
    for (genvar gi = 0; gi < c_num_blk; gi++) begin : g_cla
      cla4 u_cla4 (
        .a     (A[gi*CLA_BLOCK +: CLA_BLOCK]),
        .b     (B[gi*CLA_BLOCK +: CLA_BLOCK]),
        .c_in  (w_carry[gi]),
        .s     (w_sum[gi*CLA_BLOCK +: CLA_BLOCK]),
        .c_out (w_carry[gi+1])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_sum  <= w_sum;
        r_cout <= w_carry[c_num_blk];
      end
    end
  end

  assign sum       = r_sum;
  assign cout      = r_cout;
  assign out_valid = r_valid;

`ifdef ADDER_OVERFLOW_EN
  logic w_of;
  logic r_of;

  // Operands agree in sign but the result does not.
  assign w_of = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_of <= 1'b0;
    end else if (in_valid) begin
      r_of <= w_of;
    end
  end

  assign of = r_of;
`endif

endmodule : adder32

`default_nettype wire

// File: tb/tb_adder32.sv
// ============================================================================
// tb_adder32 : scoreboard bench for adder32 with a plain-arithmetic model
// Rev 1.0   : initial release
// ============================================================================
`default_nettype none

module tb_adder32;
  import adder_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  in_valid = 1'b0;
  word_t A = '0;
  word_t B = '0;
  logic  cin = 1'b0;
  word_t sum;
  logic  cout;
  logic  out_valid;
`ifdef ADDER_OVERFLOW_EN
  logic  of;
`endif

  adder32 #(.WIDTH(ADDER_WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .cin       (cin),
    .sum       (sum),
    .cout      (cout),
    .out_valid (out_valid)
`ifdef ADDER_OVERFLOW_EN
    ,
    .of        (of)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        o;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  logic rst_seen = 1'b0;
  logic [31:0] hold_sum = '0;
  logic        hold_cout = 1'b0;
  logic        hold_of = 1'b0;

  always @(posedge clk) begin
    cyc++;
    rst_seen <= rst_n;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: exact integer arithmetic, overflow judged on signed range.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic c);
    exp_t   e;
    longint ua, ub, us, sa, sb, ss;
    ua = longint'(a);
    ub = longint'(b);
    us = ua + ub + longint'(c);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ss = sa + sb + longint'(c);
    e.s   = us[31:0];
    e.c   = (us >= 64'sd4294967296);
    e.o   = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
    e.cyc = 0;
    return e;
  endfunction

  task automatic issue(input logic v, input logic rn, input logic [31:0] a,
                       input logic [31:0] b, input logic c);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid = v;
    rst_n    = rn;
    A        = a;
    B        = b;
    cin      = c;
    if (v && rn) begin
      e     = model(a, b, c);
      e.cyc = cyc + 1;
      q.push_back(e);
    end
  endtask

  // Monitor: samples on the falling edge, between active edges.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_seen) begin
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_sum", 64'(sum), 64'd0);
      chk("rst_cout", 64'(cout), 64'd0);
`ifdef ADDER_OVERFLOW_EN
      chk("rst_of", 64'(of), 64'd0);
`endif
      hold_sum  = '0;
      hold_cout = 1'b0;
      hold_of   = 1'b0;
    end else if (out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_out_valid", 64'(out_valid), 64'd0);
      end else begin
        e = q.pop_front();
        chk("latency_cycle", 64'(cyc), 64'(e.cyc));
        chk("sum", 64'(sum), 64'(e.s));
        chk("cout", 64'(cout), 64'(e.c));
`ifdef ADDER_OVERFLOW_EN
        chk("of", 64'(of), 64'(e.o));
`endif
        hold_sum  = e.s;
        hold_cout = e.c;
        hold_of   = e.o;
      end
    end else begin
      if (q.size() > 0 && q[0].cyc <= cyc) begin
        chk("out_valid_due", 64'(out_valid), 64'd1);
        void'(q.pop_front());
      end
      chk("hold_sum", 64'(sum), 64'(hold_sum));
      chk("hold_cout", 64'(cout), 64'(hold_cout));
`ifdef ADDER_OVERFLOW_EN
      chk("hold_of", 64'(of), 64'(hold_of));
`endif
    end
  end

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h0000_0000;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    // Reset held with valid random operands.
    repeat (2) issue(1'b1, 1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)));

    issue(1'b1, 1'b1, 32'hCCC9_CCC9, 32'h3273_39C9, 1'b0);
    issue(1'b1, 1'b1, 32'hCCC9_CCC9, 32'hF273_39C9, 1'b0);
    issue(1'b1, 1'b1, 32'h7CC9_CCC9, 32'h7273_39C9, 1'b0);
    issue(1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    repeat (3) issue(1'b0, 1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)));

    issue(1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0);
    issue(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    issue(1'b1, 1'b1, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1);
    issue(1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    issue(1'b0, 1'b1, '0, '0, 1'b0);

    // Back-to-back stream with reset on its third operation.
    issue(1'b1, 1'b1, $urandom, $urandom, 1'b0);
    issue(1'b1, 1'b1, $urandom, $urandom, 1'b1);
    issue(1'b1, 1'b0, $urandom, $urandom, 1'b0);
    issue(1'b1, 1'b1, $urandom, $urandom, 1'b1);
    issue(1'b0, 1'b1, '0, '0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      issue($urandom_range(0, 3) != 0, $urandom_range(0, 31) != 0,
            pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
    end

    repeat (3) issue(1'b0, 1'b1, '0, '0, 1'b0);
    @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_adder32

`default_nettype wire
